// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared widths, default frame geometry, capture-state type and
//               SDRAM address packing for the camera capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int ADDR_W    = 25;
    localparam int PIX_W     = 10;
    localparam int IDX_W     = 19;
    localparam int WORD_W    = ADDR_W + PIX_W;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_SYNC      = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_FLUSH     = 2'd3
    } cap_state_t;

    // SDRAM word address: upper bits zero, then the bank bit, then pixel index.
    function automatic logic [ADDR_W-1:0] make_addr(input logic bank,
                                                    input logic [IDX_W-1:0] idx);
        return {{(ADDR_W-IDX_W-1){1'b0}}, bank, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Show-ahead FIFO with a registered head. DEPTH entries in
//               total (the head counts as one). A word written into an empty
//               FIFO is presented one cycle after the write.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;

    logic               w_pop;
    logic               w_wr;
    logic [c_ptr_w-1:0] w_rd_next;
    logic [c_cnt_w-1:0] w_left;

    assign w_pop     = r_valid & out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_wr      = push & (~full | w_pop);
    assign w_rd_next = r_rd_ptr + c_ptr_w'(w_pop);
    // Entries already stored before this edge that remain after the pop; only
    // these may be presented, which gives the one-cycle write-to-head latency.
    assign w_left    = r_count - c_cnt_w'(w_pop);

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= r_count - c_cnt_w'(w_pop) + c_cnt_w'(w_wr);
            r_valid  <= (w_left != '0);
            if (w_left != '0) begin
                r_data <= r_mem[w_rd_next];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
// Module      : cam_capture
// Description : Camera frame capture. Tracks vsync framing, counts x/y for
//               each accepted pixel, builds the SDRAM word address in a
//               double-buffered bank and queues {addr, data} in a FIFO toward
//               the SDRAM write side. Frames that lose pixels keep the bank.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [PIX_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              bank,
    output logic              frame_done,
    output logic              frame_bad,
    output logic              overflow
);

    localparam int c_x_w = $clog2(H_RES);
    localparam int c_y_w = $clog2(V_RES + 1);
    localparam logic [c_x_w-1:0] c_x_last = c_x_w'(H_RES - 1);
    localparam logic [c_y_w-1:0] c_v_res  = c_y_w'(V_RES);

    cap_state_t       r_state;
    logic             r_vsync_d;
    logic [c_x_w-1:0] r_x;
    logic [c_y_w-1:0] r_y;
    logic             r_bank;
    logic             r_bad;
    logic             r_frame_done;
    logic             r_frame_bad;
    logic             r_overflow;

    logic              w_vs_rise;
    logic              w_vs_fall;
    logic              w_accept;
    logic              w_in_frame;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_drop;
    logic [IDX_W-1:0]  w_idx;
    logic [WORD_W-1:0] w_push_word;
    logic [WORD_W-1:0] w_head;

    assign w_vs_rise  = vsync & ~r_vsync_d;
    assign w_vs_fall  = ~vsync & r_vsync_d;
    assign w_accept   = (r_state == ST_CAPTURE) & href & pix_valid;
    // Lines beyond V_RES are swallowed without counting as a loss.
    assign w_in_frame = (r_y < c_v_res);
    assign w_pop      = wr_valid & wr_ready;
    assign w_push     = w_accept & w_in_frame & (~w_full | w_pop);
    assign w_drop     = w_accept & w_in_frame & w_full & ~w_pop;

    assign w_idx       = IDX_W'(r_y) * IDX_W'(H_RES) + IDX_W'(r_x);
    assign w_push_word = {make_addr(r_bank, w_idx), pix_data};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_word),
        .out_ready (wr_ready),
        .out_valid (wr_valid),
        .out_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign wr_addr    = w_head[WORD_W-1:PIX_W];
    assign wr_data    = w_head[PIX_W-1:0];
    assign bank       = r_bank;
    assign frame_done = r_frame_done;
    assign frame_bad  = r_frame_bad;
    assign overflow   = r_overflow;

    // Frame FSM with pixel counters, loss tracking and bank switching.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_WAIT_SYNC;
            // Start as "vsync high" so a level already present at reset
            // release never reads as a rising edge.
            r_vsync_d    <= 1'b1;
            r_x          <= '0;
            r_y          <= '0;
            r_bank       <= 1'b0;
            r_bad        <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_bad  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_vsync_d    <= vsync;
            r_frame_done <= 1'b0;
            r_frame_bad  <= 1'b0;

            if (w_drop) begin
                r_overflow <= 1'b1;
                r_bad      <= 1'b1;
            end

            // Position advances for every accepted pixel, kept or not; y
            // saturates at V_RES so long frames cannot wrap into the image.
            if (w_accept) begin
                if (r_x == c_x_last) begin
                    r_x <= '0;
                    if (w_in_frame) begin
                        r_y <= r_y + c_y_w'(1);
                    end
                end else begin
                    r_x <= r_x + c_x_w'(1);
                end
            end

            case (r_state)
                ST_WAIT_SYNC: begin
                    if (w_vs_rise) begin
                        r_state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_vs_fall) begin
                        r_state <= ST_CAPTURE;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vs_rise) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_empty) begin
                        r_state      <= ST_SYNC;
                        r_frame_done <= 1'b1;
                        r_frame_bad  <= r_bad;
                        // A lossy frame keeps its bank so the next frame
                        // overwrites it.
                        r_bank       <= r_bank ^ ~r_bad;
                        r_bad        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_SYNC;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_capture
// Description : Self-checking bench for cam_capture (640 x 4 frame, depth 8).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cam_capture;

    localparam int TB_H = 640;
    localparam int TB_V = 4;
    localparam int TB_D = 8;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        vsync     = 1'b0;
    logic        href      = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_data  = '0;
    logic        wr_ready  = 1'b0;
    logic        wr_valid;
    logic [9:0]  wr_data;
    logic [24:0] wr_addr;
    logic        bank;
    logic        frame_done;
    logic        frame_bad;
    logic        overflow;

    cam_capture #(
        .H_RES      (TB_H),
        .V_RES      (TB_V),
        .FIFO_DEPTH (TB_D)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .href       (href),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .bank       (bank),
        .frame_done (frame_done),
        .frame_bad  (frame_bad),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_pops = 0;
    bit          mon_en = 1'b0;
    logic [34:0] exp_q [$];

    typedef struct packed {
        logic       rst_n;
        logic       vs;
        logic       hr;
        logic       pv;
        logic [9:0] d;
        logic       rdy;
        logic       e_valid;
        logic [9:0] e_data;
        logic [24:0] e_addr;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [9:0] d);
        href      = 1'b1;
        pix_valid = 1'b1;
        pix_data  = d;
        tick();
    endtask

    task automatic idle(input int n);
        href      = 1'b0;
        pix_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic end_frame(input logic e_bad, input logic e_bank, input string tag);
        bit seen;
        seen      = 1'b0;
        href      = 1'b0;
        pix_valid = 1'b0;
        wr_ready  = 1'b1;
        vsync     = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (frame_done) seen = 1'b1;
        end
        check({tag, "_frame_done_seen"}, 64'(seen), 64'(1));
        if (seen) begin
            check({tag, "_frame_bad"}, 64'(frame_bad), 64'(e_bad));
            check({tag, "_bank"}, 64'(bank), 64'(e_bank));
            tick();
            check({tag, "_frame_done_pulse_end"}, 64'(frame_done), 64'(0));
            check({tag, "_bank_hold"}, 64'(bank), 64'(e_bank));
        end
    endtask

    // Scoreboard: every transfer on the write side must match the next
    // expected {addr, data}.
    always @(negedge clk) begin
        if (mon_en && reset_n && wr_valid && wr_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: actual addr=%0h data=%0h required=no transfer at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                check("write_stream", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rst vs hr pv data rdy | valid data addr
        vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd5,  1'b1, 1'b0, 10'd0,  25'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd6,  1'b1, 1'b0, 10'd0,  25'd0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd7,  1'b1, 1'b0, 10'd0,  25'd0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd0,  25'd0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd0,  25'd0};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd9,  1'b1, 1'b0, 10'd0,  25'd0};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd10, 1'b0, 1'b0, 10'd0,  25'd0};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd11, 1'b0, 1'b1, 10'd10, 25'd0};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd12, 1'b0, 1'b1, 10'd10, 25'd0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd13, 1'b1, 1'b1, 10'd11, 25'd1};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'd14, 1'b1, 1'b1, 10'd13, 25'd2};
        vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd0,  25'd0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd0,  25'd0};

        // Reset, power-up with vsync low and href active, sync, head latency.
        for (int i = 0; i < 13; i++) begin
            reset_n   = vt[i].rst_n;
            vsync     = vt[i].vs;
            href      = vt[i].hr;
            pix_valid = vt[i].pv;
            pix_data  = vt[i].d;
            wr_ready  = vt[i].rdy;
            tick();
            check($sformatf("vec%0d_wr_valid", i), 64'(wr_valid), 64'(vt[i].e_valid));
            if (vt[i].e_valid || !vt[i].rst_n) begin
                check($sformatf("vec%0d_wr_data", i), 64'(wr_data), 64'(vt[i].e_data));
                check($sformatf("vec%0d_wr_addr", i), 64'(wr_addr), 64'(vt[i].e_addr));
            end
            check($sformatf("vec%0d_bank", i), 64'(bank), 64'(0));
            check($sformatf("vec%0d_frame_done", i), 64'(frame_done), 64'(0));
            check($sformatf("vec%0d_frame_bad", i), 64'(frame_bad), 64'(0));
            check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(0));
        end

        // Mid-line reset with five entries queued.
        wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_pixel(10'(100 + k));
        check("pre_reset_wr_valid", 64'(wr_valid), 64'(1));
        check("pre_reset_head_addr", 64'(wr_addr), 64'(3));
        check("pre_reset_head_data", 64'(wr_data), 64'(100));
        pix_data = 10'd200;
        reset_n  = 1'b0;
        #1;
        check("async_reset_wr_valid", 64'(wr_valid), 64'(0));
        check("async_reset_wr_addr", 64'(wr_addr), 64'(0));
        tick();
        tick();
        mon_en   = 1'b1;
        wr_ready = 1'b1;
        reset_n  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send_pixel(10'(300 + k));
            check("post_reset_no_write", 64'(wr_valid), 64'(0));
        end

        // Fresh rise/fall, then a full 640 x 4 frame plus one surplus line.
        idle(1);
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        idle(2);
        for (int ln = 0; ln < TB_V; ln++) begin
            for (int col = 0; col < TB_H; col++) begin
                logic [9:0] d;
                d = (ln == 0) ? 10'(col + 1) : 10'((ln * 37 + col) % 1024);
                exp_q.push_back({25'(ln * TB_H + col), d});
                send_pixel(d);
            end
            idle(2);
            if (ln == 0) check("line0_overflow", 64'(overflow), 64'(0));
        end
        for (int k = 0; k < 10; k++) send_pixel(10'(k));
        idle(6);
        check("frame1_drained", 64'(exp_q.size()), 64'(0));
        check("surplus_line_no_overflow", 64'(overflow), 64'(0));
        end_frame(1'b0, 1'b1, "frame1");

        // Bank 1: fill to full, then push and pop together.
        vsync    = 1'b0;
        idle(2);
        wr_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({25'(32'h80000 + k), 10'(400 + k)});
            send_pixel(10'(400 + k));
        end
        check("full_head_addr", 64'(wr_addr), 64'(32'h80000));
        check("full_head_valid", 64'(wr_valid), 64'(1));
        wr_ready = 1'b1;
        for (int k = 8; k < 12; k++) begin
            exp_q.push_back({25'(32'h80000 + k), 10'(400 + k)});
            send_pixel(10'(400 + k));
        end
        idle(12);
        check("frame2_drained", 64'(exp_q.size()), 64'(0));
        check("push_pop_full_no_overflow", 64'(overflow), 64'(0));
        end_frame(1'b0, 1'b0, "frame2");

        // Bank 0: ten pixels into a stalled FIFO, two are lost.
        vsync    = 1'b0;
        idle(2);
        wr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) exp_q.push_back({25'(k), 10'(500 + k)});
            send_pixel(10'(500 + k));
        end
        check("drop_overflow", 64'(overflow), 64'(1));
        idle(3);
        check("stall_head_valid", 64'(wr_valid), 64'(1));
        check("stall_head_addr", 64'(wr_addr), 64'(0));
        check("stall_head_data", 64'(wr_data), 64'(500));
        wr_ready = 1'b1;
        idle(12);
        check("frame3_drained", 64'(exp_q.size()), 64'(0));
        end_frame(1'b1, 1'b0, "frame3");
        check("overflow_sticky", 64'(overflow), 64'(1));
        check("total_writes", 64'(n_pops), 64'(TB_H * TB_V + 12 + 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
